shared_bus_arbiter: RTL
=======================

Name: shared_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared W-bit word bus with tri-state drivers.
- Up to N requesters each present a data word and a request line. The block grants one requester at a time, drives the per-requester tri-state enables and the word-mux select, and inserts one turnaround cycle between owners so that no two drivers ever overlap.
- It sits between the requesting units and the shared bus (tri-state enables plus the equivalent muxed bus_out).

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, bus word width.
- SEL_W, 2, select width; must equal ceil(log2(N)).
- MAX_HOLD, 16, maximum consecutive grant cycles when ARB_BURST_LIMIT_EN is defined (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  N  request lines; bit i belongs to requester i.
- data_in  input  N*W  flattened words; requester i occupies bits [i*W +: W].
- gnt  output  N  registered one-hot grant.
- bus_en  output  N  tri-state driver enables; always equal to gnt.
- sel  output  SEL_W  registered index of the current/last owner.
- bus_valid  output  1  high while some requester owns the bus.
- bus_out  output  W  equals data_in word [sel] when bus_valid is high, else 0 (combinational from registered sel/bus_valid).

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, bus_en=0, sel=0, bus_valid=0, bus_out=0, rr pointer last=N-1, hold counter=0.
- States: IDLE, GRANT, TURN.
- Arbitration function:
  - Scan indices last+1, last+2, ... modulo N.
  - Pick the first i with req[i]=1.
  - Purely combinational on req sampled this cycle.
- IDLE:
  - If req!=0: next state GRANT, gnt<=onehot(i), sel<=i, bus_valid<=1, hold<=0.
  - Latency: req sampled at edge t gives gnt high after edge t+1.
  - If req==0: stay in IDLE.
- GRANT:
  - Owner keeps the bus while req[sel]=1; hold increments, saturating at MAX_HOLD-1.
  - If req[sel]=0 at an edge: next state TURN, gnt<=0, bus_valid<=0, last<=sel. sel holds its value.
  - Requests from other indices are ignored while in GRANT (no preemption).
- TURN:
  - Exactly one cycle with all enables low (bus idle).
  - Then arbitrate as in IDLE: if req!=0, go to GRANT with a new one-hot gnt; else go to IDLE.
  - Minimum gap between owners is 1 cycle.
- Round-robin fairness:
  - After requester k releases, k has the lowest priority in the next arbitration.
  - With all N requesting continuously, grants rotate k+1, k+2, ... and no requester waits more than N-1 tenures.
- Invariants:
  - gnt is one-hot or zero.
  - bus_en==gnt.
  - bus_valid==|gnt.
  - A gnt bit never rises in the same cycle another falls.
- Boundary conditions:
  - A req pulse that drops before arbitration samples it is lost; no latching.
  - With a single requester holding req high permanently, the grant never drops unless ARB_BURST_LIMIT_EN is defined.
  - If req[sel] drops and rises in the same TURN cycle, it is eligible again but at lowest priority.
  - Async rst asserted mid-GRANT drops gnt/bus_en immediately (same cycle, not at an edge). On rst release, the block resumes from IDLE with last=N-1.
- Width rules:
  - sel never exceeds N-1.
  - Indices are computed modulo N with SEL_W-bit arithmetic plus an explicit wrap when N is not a power of two.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- Defined:
  - In GRANT, when hold==MAX_HOLD-1 and req[sel] is still 1, the next edge forces GRANT->TURN with last<=sel. A tenure is therefore at most MAX_HOLD cycles.
  - The preempted requester re-enters arbitration at lowest priority. If it is the only requester, it is re-granted after the one TURN cycle.
- Undefined:
  - The hold counter and comparison are not built.
  - Tenure is unlimited; release happens only when req drops.

Test Plan:
- Reset: rst=1 mid-grant with req=4'b0010 -> gnt, bus_en and bus_valid go to 0 immediately; bus_out=0. After release and with req=4'b1111, the first grant is gnt=4'b0001 one cycle after req is sampled.
- Single owner data path: req=4'b0100, data_in word2=32'hDEADBEEF -> gnt=4'b0100, sel=2, bus_out=32'hDEADBEEF. req[2] drops -> next cycle gnt=0 (TURN), then IDLE.
- Rotation: req=4'b1111, each owner drops its req after 3 cycles and reasserts it during TURN -> grant order 0,1,2,3,0; exactly 1 idle cycle between tenures; never two gnt bits high.
- No preemption: owner 1 holds 10 cycles while req[3] is asserted from cycle 2 -> gnt[3] first rises 2 edges after req[1] drops.
- Burst limit (ARB_BURST_LIMIT_EN, MAX_HOLD=16): req=4'b0001 held forever -> gnt[0] high for 16 cycles, low 1 cycle, high again. Without the macro -> gnt[0] stays high for 100+ cycles.
- Wrap/skip: N=3, last=2, req=3'b100 -> grant index 2; then req=3'b101 -> next grant index 0.

Source files
------------

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state word bus, with one idle turnaround cycle between owners.
// Optional macro ARB_BURST_LIMIT_EN caps every tenure at MAX_HOLD cycles.
module shared_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 32,
   parameter int SEL_W    = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   data_in,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     bus_en,
   output logic [SEL_W-1:0] sel,
   output logic             bus_valid,
   output logic [W-1:0]     bus_out,
   output logic [1:0]       state_dbg
);

   // Handshake: req[i] is a level request sampled on every rising edge, with no latching.
   // gnt[i] is the registered answer. Requester i owns the bus for every cycle that gnt[i]
   // is high and keeps ownership for as long as it holds req[i]. Dropping req[i] releases
   // the bus at the next edge.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
   localparam bit CFG_OK = (N >= 2) && (N <= 8) && (SEL_W == $clog2(N)) && (MAX_HOLD >= 2);

`ifdef ARB_BURST_LIMIT_EN
   localparam int              HOLD_W    = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
`endif

   logic [1:0]       state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] last_q, last_d;
`ifdef ARB_BURST_LIMIT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
`endif

   logic [SEL_W-1:0] scan_idx;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic             drop_own;

   // Scan starts one past the previous owner, so that owner has the lowest priority.
   // The explicit wrap keeps the index legal when N is not a power of two.
   always_comb begin
      scan_idx   = last_q;
      pick_idx   = '0;
      pick_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      valid_d  = valid_q;
      last_d   = last_q;
      drop_own = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      hold_d   = hold_q;
`endif
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (pick_found) begin
               state_d = ST_GRANT;
               gnt_d   = ONE_HOT0 << pick_idx;
               sel_d   = pick_idx;
               valid_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
               hold_d  = '0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            drop_own = !req[sel_q];
`ifdef ARB_BURST_LIMIT_EN
            drop_own = drop_own || (hold_q == HOLD_LAST);
`endif
            // sel keeps the last owner during TURN; only the enables go low.
            if (drop_own) begin
               state_d = ST_TURN;
               gnt_d   = '0;
               valid_d = 1'b0;
               last_d  = sel_q;
            end
`ifdef ARB_BURST_LIMIT_EN
            else begin
               hold_d = hold_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= LAST_IDX;
`ifdef ARB_BURST_LIMIT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         last_q  <= last_d;
`ifdef ARB_BURST_LIMIT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   always_comb begin
      bus_out = '0;
      if (valid_q) begin
         bus_out = data_in[sel_q*W +: W];
      end
   end

   assign gnt       = gnt_q;
   assign bus_en    = gnt_q;
   assign sel       = sel_q;
   assign bus_valid = valid_q;
   assign state_dbg = state_q;

   a_cfg: assert property (@(posedge clk) CFG_OK);
   a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
   a_valid: assert property (@(posedge clk) disable iff (rst) valid_q == (gnt_q != '0));
   a_sel_range: assert property (@(posedge clk) disable iff (rst) sel_q <= LAST_IDX);
   a_no_overlap: assert property (@(posedge clk) disable iff (rst)
      (gnt_q != '0) |=> ((gnt_q == '0) || (gnt_q == $past(gnt_q))));

endmodule
